// File: rtl/oam_dma.sv
// OAM DMA engine: copies NUM_BYTES bytes from page {src_page, 8'h00} into OAM,
// spending CYCLES_PER_BYTE clocks per byte, with a fixed source read latency.
module oam_dma #(
    parameter int CYCLES_PER_BYTE = 4,
    parameter int READ_LAT        = 1,
    parameter int NUM_BYTES       = 160
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  src_page,
    output logic        busy,
    output logic        done,
    output logic [15:0] src_addr_select,
    input  logic [7:0]  src_read_out,
    output logic [7:0]  oam_addr_select,
    output logic [7:0]  oam_write_value,
    output logic        oam_write_enable
);

    localparam int PW = (CYCLES_PER_BYTE > 1) ? $clog2(CYCLES_PER_BYTE) : 1;
    localparam logic [PW-1:0] PH_LAST  = PW'(CYCLES_PER_BYTE - 1);
    localparam logic [PW-1:0] PH_WR    = PW'(READ_LAT - 1);
    localparam logic [7:0]    IDX_LAST = 8'(NUM_BYTES - 1);

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t        state;
    logic [7:0]    page_reg;
    logic [7:0]    idx;
    logic [PW-1:0] ph;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            page_reg         <= 8'h00;
            idx              <= 8'h00;
            ph               <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            src_addr_select  <= 16'h0000;
            oam_addr_select  <= 8'h00;
            oam_write_enable <= 1'b0;
        end else begin
            done             <= 1'b0;
            oam_write_enable <= 1'b0;
            // A start strobe always wins, including over the final wrap.
            if (start) begin
                state           <= XFER;
                busy            <= 1'b1;
                page_reg        <= src_page;
                idx             <= 8'h00;
                ph              <= '0;
                src_addr_select <= {src_page, 8'h00};
            end else if (state == XFER) begin
                if (ph == PH_LAST) begin
                    ph <= '0;
                    if (idx == IDX_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        idx             <= idx + 8'd1;
                        src_addr_select <= {page_reg, idx + 8'd1};
                    end
                end else begin
                    ph <= ph + PW'(1);
                    // Strobe is registered one cycle early so it lands at ph == READ_LAT.
                    if (ph == PH_WR) begin
                        oam_write_enable <= 1'b1;
                        oam_addr_select  <= idx;
                    end
                end
            end
        end
    end

    // Source data only becomes valid in the write cycle itself, so it is
    // forwarded through a gate rather than registered a second time.
    assign oam_write_value = oam_write_enable ? src_read_out : 8'h00;

endmodule
